// File: rtl/line_code_pkg.sv
// line_code_pkg
//   Shared definitions for the multi-channel line encoder.
//   - lc_mode_e  : per-word line code, encoded as on the MODE port
//   - lc_state_e : encoder FSM state
package line_code_pkg;

   typedef enum logic [1:0] {
      LC_NRZ   = 2'b00,
      LC_NRZI  = 2'b01,
      LC_AMI   = 2'b10,
      LC_MANCH = 2'b11
   } lc_mode_e;

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } lc_state_e;

endpackage

// File: rtl/line_code_channel.sv
// line_code_channel
//   One serialised line. Holds the word shift register, the bit currently on
//   the line, the persistent AMI polarity and NRZI level, and the registered
//   P/N marks. The top sequences it; this block only produces the symbols.
// Ports:
//   CLK, CPU_RESET   clock, synchronous active-high reset
//   load             load in_word and emit the first symbol of its first bit
//   adv              advance to the next bit and emit its first symbol
//   sym_en           a symbol is emitted at this edge (else line goes zero)
//   second_half      emitted symbol is the second half of a Manchester bit
//   mode             line code of the emitted symbol
//   in_word          parallel word for this channel
//   line_p, line_n   registered positive / negative marks
module line_code_channel
   import line_code_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              CLK,
   input  logic              CPU_RESET,
   input  logic              load,
   input  logic              adv,
   input  logic              sym_en,
   input  logic              second_half,
   input  lc_mode_e          mode,
   input  logic [WORD_W-1:0] in_word,
   output logic              line_p,
   output logic              line_n
);

   logic [WORD_W-1:0] shreg_q, shreg_d, src;
   logic              cur_bit_q, cur_bit_d;
   logic              ami_neg_q, ami_neg_d;    // 1: next AMI mark is negative
   logic              nrzi_lvl_q, nrzi_lvl_d;
   logic              p_q, p_d, n_q, n_d;

   always_comb begin
      src        = load ? in_word : shreg_q;
      shreg_d    = shreg_q;
      cur_bit_d  = cur_bit_q;
      ami_neg_d  = ami_neg_q;
      nrzi_lvl_d = nrzi_lvl_q;
      p_d        = 1'b0;
      n_d        = 1'b0;

      // shreg holds only the bits not yet put on the line
      if (load || adv) begin
         cur_bit_d = MSB_FIRST ? src[WORD_W-1] : src[0];
         shreg_d   = MSB_FIRST ? (src << 1) : (src >> 1);
      end

      if (sym_en) begin
         unique case (mode)
            LC_NRZ: begin
               p_d = cur_bit_d;
               n_d = !cur_bit_d;
            end
            LC_NRZI: begin
               if (cur_bit_d) nrzi_lvl_d = !nrzi_lvl_q;
               p_d = nrzi_lvl_d;
               n_d = !nrzi_lvl_d;
            end
            LC_AMI: begin
               if (cur_bit_d) begin
                  p_d       = !ami_neg_q;
                  n_d       = ami_neg_q;
                  ami_neg_d = !ami_neg_q;
               end
            end
            LC_MANCH: begin
               // 1: low then high, 0: high then low
               p_d = second_half ? cur_bit_d : !cur_bit_d;
               n_d = !p_d;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (CPU_RESET) begin
         shreg_q    <= '0;
         cur_bit_q  <= 1'b0;
         ami_neg_q  <= 1'b0;
         nrzi_lvl_q <= 1'b0;
         p_q        <= 1'b0;
         n_q        <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         cur_bit_q  <= cur_bit_d;
         ami_neg_q  <= ami_neg_d;
         nrzi_lvl_q <= nrzi_lvl_d;
         p_q        <= p_d;
         n_q        <= n_d;
      end
   end

   assign line_p = p_q;
   assign line_n = n_q;

endmodule

// File: rtl/line_code_encoder.sv
// line_code_encoder
//   Multi-channel serial line encoder. One word per channel is accepted via a
//   valid/ready handshake and serialised onto a P/N pair per channel using
//   NRZ, NRZI, AMI or Manchester, chosen per word.
// Ports:
//   CLK, CPU_RESET   clock, synchronous active-high reset
//   MODE             line code, sampled on accept
//   IN_VALID         word available
//   IN_READY         word can be accepted this cycle
//   IN_DATA          channel c in bits [c*WORD_W +: WORD_W]
//   LINE_P, LINE_N   per-channel marks (both 0 = line zero)
//   BIT_STROBE       high on the first symbol of every bit
//   BUSY             a word's symbols are on the line
module line_code_encoder
   import line_code_pkg::*;
#(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned WORD_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                       CLK,
   input  logic                       CPU_RESET,
   input  logic [1:0]                 MODE,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [CHANNELS*WORD_W-1:0] IN_DATA,
   output logic [CHANNELS-1:0]        LINE_P,
   output logic [CHANNELS-1:0]        LINE_N,
   output logic                       BIT_STROBE,
   output logic                       BUSY
);

   localparam int unsigned     CntW    = $clog2(WORD_W);
   localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

   lc_state_e       state_q, state_d;
   lc_mode_e        mode_q, mode_d, sym_mode;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            half_q, half_d;     // symbol on the line is a second half
   logic            strobe_q, strobe_d;
   logic            last_sym, accept;
   logic            load, adv, sym_en, second_half;

   // State register
   always_ff @(posedge CLK) begin
      if (CPU_RESET) begin
         state_q  <= StIdle;
         mode_q   <= LC_NRZ;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         strobe_q <= strobe_d;
      end
   end

   // Next state; the symbol for the next cycle is decided here and
   // registered in the channels, so accept and first symbol share an edge.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      strobe_d    = 1'b0;
      load        = 1'b0;
      adv         = 1'b0;
      sym_en      = 1'b0;
      second_half = 1'b0;
      sym_mode    = mode_q;

      if (accept) begin
         state_d  = StSend;
         mode_d   = lc_mode_e'(MODE);
         sym_mode = lc_mode_e'(MODE);
         cnt_d    = '0;
         half_d   = 1'b0;
         strobe_d = 1'b1;
         load     = 1'b1;
         sym_en   = 1'b1;
      end else if (state_q == StSend) begin
         if (last_sym) begin
            state_d = StIdle;
         end else if (mode_q == LC_MANCH && !half_q) begin
            half_d      = 1'b1;
            second_half = 1'b1;
            sym_en      = 1'b1;
         end else begin
            cnt_d    = cnt_q + 1'b1;
            half_d   = 1'b0;
            adv      = 1'b1;
            sym_en   = 1'b1;
            strobe_d = 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      last_sym   = (state_q == StSend) && (cnt_q == LastBit) &&
                   ((mode_q != LC_MANCH) || half_q);
      IN_READY   = !CPU_RESET && ((state_q == StIdle) || last_sym);
      accept     = IN_VALID && IN_READY;
      BUSY       = (state_q == StSend);
      BIT_STROBE = strobe_q;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      line_code_channel #(
         .WORD_W    (WORD_W),
         .MSB_FIRST (MSB_FIRST)
      ) u_chan (
         .CLK         (CLK),
         .CPU_RESET   (CPU_RESET),
         .load        (load),
         .adv         (adv),
         .sym_en      (sym_en),
         .second_half (second_half),
         .mode        (sym_mode),
         .in_word     (IN_DATA[c*WORD_W +: WORD_W]),
         .line_p      (LINE_P[c]),
         .line_n      (LINE_N[c])
      );
   end

endmodule

// File: tb/tb_line_code_encoder.sv
// tb_line_code_encoder
//   Two encoders (MSB-first and LSB-first) share one stimulus stream. Each
//   accepted word is expanded by a behavioural model into per-cycle expected
//   symbols on a scoreboard queue; every cycle the queue front is compared
//   against both DUTs along with BUSY, BIT_STROBE and IN_READY.
module tb_line_code_encoder;

   localparam int unsigned CH = 2;
   localparam int unsigned W  = 8;
   localparam int unsigned VW = 3 + 2 * CH;
   localparam logic [1:0] M_NRZ = 2'b00, M_NRZI = 2'b01, M_AMI = 2'b10, M_MANCH = 2'b11;

   typedef struct packed {
      logic                strobe;
      logic [1:0][CH-1:0] p;      // [dut][channel], dut 0 = MSB first
      logic [1:0][CH-1:0] n;
   } sym_t;

   logic            clk = 1'b0;
   logic            cpu_reset = 1'b1;
   logic            in_valid = 1'b0;
   logic [1:0]      mode = 2'b00;
   logic [CH*W-1:0] in_data = '0;
   logic            rdy0, rdy1, strb0, strb1, busy0, busy1;
   logic [CH-1:0]   p0, n0, p1, n1;

   sym_t               sb_q[$];
   logic [1:0][CH-1:0] m_pol;   // 1: next AMI mark negative
   logic [1:0][CH-1:0] m_lvl;
   int                 n_vec = 0;
   int                 n_err = 0;
   bit                 acc_flag = 1'b0;
   bit                 chk_en = 1'b0;
   string              phase = "reset";

   always #5 clk = ~clk;

   line_code_encoder #(.CHANNELS(CH), .WORD_W(W), .MSB_FIRST(1'b1)) dut_msb (
      .CLK        (clk),
      .CPU_RESET  (cpu_reset),
      .MODE       (mode),
      .IN_VALID   (in_valid),
      .IN_READY   (rdy0),
      .IN_DATA    (in_data),
      .LINE_P     (p0),
      .LINE_N     (n0),
      .BIT_STROBE (strb0),
      .BUSY       (busy0)
   );

   line_code_encoder #(.CHANNELS(CH), .WORD_W(W), .MSB_FIRST(1'b0)) dut_lsb (
      .CLK        (clk),
      .CPU_RESET  (cpu_reset),
      .MODE       (mode),
      .IN_VALID   (in_valid),
      .IN_READY   (rdy1),
      .IN_DATA    (in_data),
      .LINE_P     (p1),
      .LINE_N     (n1),
      .BIT_STROBE (strb1),
      .BUSY       (busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Expand one word into its expected symbol stream for both DUTs.
   task automatic push_word(input logic [1:0] m, input logic [CH*W-1:0] d);
      sym_t e;
      logic b;
      int   halves;
      halves = (m == M_MANCH) ? 2 : 1;
      for (int k = 0; k < W; k++) begin
         for (int h = 0; h < halves; h++) begin
            e        = '0;
            e.strobe = (h == 0);
            for (int u = 0; u < 2; u++) begin
               for (int c = 0; c < CH; c++) begin
                  b = d[c * W + ((u == 0) ? (W - 1 - k) : k)];
                  case (m)
                     M_NRZ: begin
                        e.p[u][c] = b;
                        e.n[u][c] = !b;
                     end
                     M_NRZI: begin
                        if (b) m_lvl[u][c] = !m_lvl[u][c];
                        e.p[u][c] = m_lvl[u][c];
                        e.n[u][c] = !m_lvl[u][c];
                     end
                     M_AMI: begin
                        if (b) begin
                           e.p[u][c]   = !m_pol[u][c];
                           e.n[u][c]   = m_pol[u][c];
                           m_pol[u][c] = !m_pol[u][c];
                        end
                     end
                     default: begin
                        e.p[u][c] = (h == 1) ? b : !b;
                        e.n[u][c] = (h == 1) ? !b : b;
                     end
                  endcase
               end
            end
            sb_q.push_back(e);
         end
      end
   endtask

   // Model side of the handshake: retire the symbol just shown, take a word.
   always @(posedge clk) begin
      bit rdy;
      rdy      = !cpu_reset && (sb_q.size() <= 1);
      acc_flag = 1'b0;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      if (cpu_reset) begin
         sb_q.delete();
         m_pol = '0;
         m_lvl = '0;
      end else if (in_valid && rdy) begin
         acc_flag = 1'b1;
         push_word(mode, in_data);
      end
   end

   always @(negedge clk) begin
      sym_t           e;
      logic           er, eb;
      logic [VW-1:0]  exp0, exp1;
      if (chk_en) begin
         er = !cpu_reset && (sb_q.size() <= 1);
         if (sb_q.size() > 0) begin
            e  = sb_q[0];
            eb = 1'b1;
         end else begin
            e  = '0;
            eb = 1'b0;
         end
         exp0 = {er, eb, e.strobe, e.p[0], e.n[0]};
         exp1 = {er, eb, e.strobe, e.p[1], e.n[1]};
         check({phase, "/msb"}, 32'({rdy0, busy0, strb0, p0, n0}), 32'(exp0));
         check({phase, "/lsb"}, 32'({rdy1, busy1, strb1, p1, n1}), 32'(exp1));
      end
   end

   // Offer a word and hold it until taken; then scramble the inputs so a
   // DUT that fails to latch them on accept shows up.
   task automatic send_word(input logic [1:0] m, input logic [CH*W-1:0] d);
      bit done;
      done     = 1'b0;
      mode     = m;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk);
         #1;
         done = acc_flag;
      end
      in_valid = 1'b0;
      mode     = m ^ 2'b01;
      in_data  = ~d;
      if (!done) check({phase, "/accept_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         @(posedge clk);
         #1;
         idle = (sb_q.size() == 0);
      end
      if (!idle) check({phase, "/idle_timeout"}, 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cpu_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      phase = "ami";
      send_word(M_AMI, {8'h00, 8'b1011_0001});
      wait_idle();
      send_word(M_AMI, {8'h5A, 8'h01});
      wait_idle();

      phase = "manch";
      send_word(M_MANCH, {8'h3C, 8'hA5});
      wait_idle();

      phase = "nrzi";
      send_word(M_NRZI, {8'hFF, 8'hFF});
      send_word(M_NRZI, {8'h00, 8'h00});
      wait_idle();

      phase = "ami_rst";
      send_word(M_AMI, {8'hFF, 8'hFF});
      repeat (2) @(posedge clk);
      #1;
      cpu_reset = 1'b1;
      @(posedge clk);
      #1;
      cpu_reset = 1'b0;
      @(posedge clk);
      #1;
      send_word(M_AMI, {8'h80, 8'h80});
      wait_idle();

      phase = "nrz";
      send_word(M_NRZ, {8'h03, 8'hC5});
      wait_idle();

      phase = "b2b_mix";
      send_word(M_MANCH, {8'h81, 8'h7E});
      send_word(M_AMI, {8'hF0, 8'h0F});
      send_word(M_NRZI, {8'h96, 8'h69});
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
